// File: rtl/dynamixel_status_receiver_pkg.sv
// Shared Dynamixel 2.0 constants, FSM state types and the CRC-16 step function.
package dynamixel_status_receiver_pkg;

  localparam logic [7:0]  HdrByte1       = 8'hFF;
  localparam logic [7:0]  HdrByte2       = 8'hFF;
  localparam logic [7:0]  HdrByte3       = 8'hFD;
  localparam logic [7:0]  ReservedByte   = 8'h00;
  localparam logic [7:0]  BroadcastId    = 8'hFE;
  localparam logic [7:0]  InstrSyncWrite = 8'h83;
  localparam logic [7:0]  InstrStatus    = 8'h55;
  localparam logic [15:0] CrcPoly        = 16'h8005;
  // LENGTH covers INSTR + ERR + CRC_L + CRC_H at minimum
  localparam logic [15:0] MinLen         = 16'd4;

  typedef enum logic [3:0] {
    StHunt1,
    StHunt2,
    StHunt3,
    StRsrv,
    StId,
    StLenL,
    StLenH,
    StInstr,
    StErr,
    StParam,
    StCrcL,
    StCrcH
  } rx_state_e;

  typedef enum logic [1:0] {
    UrIdle,
    UrStart,
    UrData,
    UrStop
  } uart_state_e;

  // One byte of CRC-16 (poly 0x8005, MSB first, no reflection); shared with the transmitter.
  function automatic logic [15:0] crc16(input logic [7:0] data, input logic [15:0] crc);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CrcPoly) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/dynamixel_status_receiver_if.sv
// Decoded status-packet result bundle between the receiver and its consumer.
interface dynamixel_status_receiver_if;
  logic        status_valid;
  logic [7:0]  id;
  logic [7:0]  error;
  logic [15:0] param_count;
  logic [31:0] value;
  logic        crc_error;
  logic        frame_error;
  logic        busy;

  modport master (
    output status_valid, id, error, param_count, value, crc_error, frame_error, busy
  );

  modport slave (
    input status_valid, id, error, param_count, value, crc_error, frame_error, busy
  );
endinterface

// File: rtl/dynamixel_status_receiver_uart_rx.sv
// 8N1 UART receiver: synchronises the bus pin, centres on each bit and emits one byte per frame.
module dynamixel_status_receiver_uart_rx
  import dynamixel_status_receiver_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pin,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stop_error
);

  localparam int unsigned CntW = $clog2(clocks_per_bit);
  localparam logic [CntW-1:0] BitLast  = CntW'(clocks_per_bit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(clocks_per_bit / 2 - 1);

  uart_state_e     state_q, state_d;
  logic [2:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            serr_q, serr_d;
  logic            rx, rx_prev;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous value for edge detect
  assign rx      = sync_q[1];
  assign rx_prev = sync_q[2];

  // Synchroniser chain, idle-high out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UrIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: falling edge -> start re-check at half bit -> 8 data bits -> stop bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UrIdle:  if (rx_prev && !rx) state_d = UrStart;
      UrStart: if (cnt_q == HalfLast) state_d = rx ? UrIdle : UrData;
      UrData:  if (cnt_q == BitLast && bit_q == 3'd7) state_d = UrStop;
      UrStop:  if (cnt_q == BitLast) state_d = UrIdle;
      default: state_d = UrIdle;
    endcase
  end

  // Bit timing, shift register and byte/error pulses.
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    serr_d  = 1'b0;
    unique case (state_q)
      UrIdle: begin
        cnt_d = '0;
        bit_d = '0;
      end
      UrStart: begin
        if (cnt_q == HalfLast) cnt_d = '0;
      end
      UrData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      UrStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            serr_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      serr_q  <= serr_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign stop_error = serr_q;

endmodule

// File: rtl/dynamixel_status_receiver.sv
// Dynamixel 2.0 status packet parser: header hunt, field capture, de-stuffing, CRC and timeout.
module dynamixel_status_receiver
  import dynamixel_status_receiver_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 16,
  parameter logic [15:0] max_len        = 16'd64,
  parameter int unsigned timeout_clocks = 4096
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        pin,
  dynamixel_status_receiver_if.master status
);

  localparam int unsigned TmoW = $clog2(timeout_clocks + 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(timeout_clocks - 1);
  localparam logic [23:0]     StuffSeq = {HdrByte1, HdrByte2, HdrByte3};

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_stop_err;

  dynamixel_status_receiver_uart_rx #(
    .clocks_per_bit(clocks_per_bit)
  ) u_uart_rx (
    .clock     (clock),
    .reset_n   (reset_n),
    .pin       (pin),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .stop_error(rx_stop_err)
  );

  rx_state_e       state_q, state_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     left_q, left_d;
  logic [23:0]     hist_q, hist_d;
  logic [7:0]      crc_lo_q, crc_lo_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  // staged fields, published only on a CRC match
  logic [7:0]      id_stg_q, id_stg_d;
  logic [7:0]      err_stg_q, err_stg_d;
  logic [15:0]     cnt_stg_q, cnt_stg_d;
  logic [31:0]     val_stg_q, val_stg_d;
  // published outputs
  logic            sv_q, sv_d;
  logic            ce_q, ce_d;
  logic            fe_q, fe_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     val_q, val_d;

  logic        busy;
  logic        timeout_hit;
  logic [15:0] crc_next;
  logic [15:0] len_full;
  logic        len_bad;
  logic        drop;

  assign busy        = !(state_q inside {StHunt1, StHunt2, StHunt3});
  // a byte arriving in the same cycle takes priority over the timeout
  assign timeout_hit = busy && !rx_valid && (tmo_q == TmoLast);
  assign crc_next    = crc16(rx_byte, crc_q);
  assign len_full    = {rx_byte, len_q[7:0]};
  assign len_bad     = (len_full < MinLen) || (len_full > max_len);
  assign drop        = (hist_q == StuffSeq) && (rx_byte == HdrByte3);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHunt1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance only on received bytes; abort to hunt on timeout or bad fields.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = StHunt1;
    end else if (rx_valid) begin
      unique case (state_q)
        StHunt1: if (rx_byte == HdrByte1) state_d = StHunt2;
        StHunt2: state_d = (rx_byte == HdrByte2) ? StHunt3 : StHunt1;
        StHunt3: begin
          if (rx_byte == HdrByte3)      state_d = StRsrv;
          else if (rx_byte == HdrByte2) state_d = StHunt3;
          else                          state_d = StHunt1;
        end
        StRsrv:  state_d = (rx_byte == ReservedByte) ? StId : StHunt1;
        StId:    state_d = StLenL;
        StLenL:  state_d = StLenH;
        StLenH:  state_d = len_bad ? StHunt1 : StInstr;
        StInstr: state_d = (rx_byte == InstrStatus) ? StErr : StHunt1;
        StErr:   state_d = (len_q == MinLen) ? StCrcL : StParam;
        StParam: state_d = (left_q == 16'd1) ? StCrcL : StParam;
        StCrcL:  state_d = StCrcH;
        StCrcH:  state_d = StHunt1;
        default: state_d = StHunt1;
      endcase
    end
  end

  // Datapath and result pulses.
  always_comb begin
    crc_d     = crc_q;
    len_d     = len_q;
    left_d    = left_q;
    hist_d    = hist_q;
    crc_lo_d  = crc_lo_q;
    id_stg_d  = id_stg_q;
    err_stg_d = err_stg_q;
    cnt_stg_d = cnt_stg_q;
    val_stg_d = val_stg_q;
    id_d      = id_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    sv_d      = 1'b0;
    ce_d      = 1'b0;
    fe_d      = rx_stop_err | timeout_hit;
    tmo_d     = (!busy || rx_valid) ? '0 : tmo_q + TmoW'(1);
    if (rx_valid) begin
      unique case (state_q)
        StHunt1: if (rx_byte == HdrByte1) crc_d = crc16(rx_byte, 16'h0000);
        StHunt2: if (rx_byte == HdrByte2) crc_d = crc_next;
        // an extra FF keeps the CRC of the last two FFs, which is already in crc_q
        StHunt3: if (rx_byte == HdrByte3) crc_d = crc_next;
        StRsrv:  crc_d = crc_next;
        StId: begin
          crc_d    = crc_next;
          id_stg_d = rx_byte;
        end
        StLenL: begin
          crc_d       = crc_next;
          len_d[7:0]  = rx_byte;
        end
        StLenH: begin
          crc_d       = crc_next;
          len_d[15:8] = rx_byte;
          if (len_bad) fe_d = 1'b1;
        end
        StInstr: begin
          crc_d = crc_next;
          if (rx_byte != InstrStatus) fe_d = 1'b1;
        end
        StErr: begin
          crc_d     = crc_next;
          err_stg_d = rx_byte;
          left_d    = len_q - MinLen;
          hist_d    = '0;
          cnt_stg_d = '0;
          val_stg_d = '0;
        end
        StParam: begin
          crc_d  = crc_next;
          hist_d = {hist_q[15:0], rx_byte};
          left_d = left_q - 16'd1;
          if (!drop) begin
            if (cnt_stg_q < 16'd4) begin
              unique case (cnt_stg_q[1:0])
                2'd0: val_stg_d[7:0]   = rx_byte;
                2'd1: val_stg_d[15:8]  = rx_byte;
                2'd2: val_stg_d[23:16] = rx_byte;
                2'd3: val_stg_d[31:24] = rx_byte;
                default: ;
              endcase
            end
            cnt_stg_d = cnt_stg_q + 16'd1;
          end
        end
        StCrcL: crc_lo_d = rx_byte;
        StCrcH: begin
          if ({rx_byte, crc_lo_q} == crc_q) begin
            sv_d  = 1'b1;
            id_d  = id_stg_q;
            err_d = err_stg_q;
            cnt_d = cnt_stg_q;
            val_d = val_stg_q;
          end else begin
            ce_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q     <= '0;
      len_q     <= '0;
      left_q    <= '0;
      hist_q    <= '0;
      crc_lo_q  <= '0;
      tmo_q     <= '0;
      id_stg_q  <= '0;
      err_stg_q <= '0;
      cnt_stg_q <= '0;
      val_stg_q <= '0;
      sv_q      <= 1'b0;
      ce_q      <= 1'b0;
      fe_q      <= 1'b0;
      id_q      <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
      val_q     <= '0;
    end else begin
      crc_q     <= crc_d;
      len_q     <= len_d;
      left_q    <= left_d;
      hist_q    <= hist_d;
      crc_lo_q  <= crc_lo_d;
      tmo_q     <= tmo_d;
      id_stg_q  <= id_stg_d;
      err_stg_q <= err_stg_d;
      cnt_stg_q <= cnt_stg_d;
      val_stg_q <= val_stg_d;
      sv_q      <= sv_d;
      ce_q      <= ce_d;
      fe_q      <= fe_d;
      id_q      <= id_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
    end
  end

  assign status.status_valid = sv_q;
  assign status.crc_error    = ce_q;
  assign status.frame_error  = fe_q;
  assign status.id           = id_q;
  assign status.error        = err_q;
  assign status.param_count  = cnt_q;
  assign status.value        = val_q;
  assign status.busy         = busy;

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Randomised packet bench for dynamixel_status_receiver with a queue-based reference model.
module tb_dynamixel_status_receiver;

  localparam int unsigned Cpb    = 8;
  localparam logic [15:0] MaxLen = 16'd32;
  localparam int unsigned Tmo    = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pin   = 1'b1;

  always #5 clk = ~clk;

  dynamixel_status_receiver_if st_if ();

  dynamixel_status_receiver #(
    .clocks_per_bit(Cpb),
    .max_len       (MaxLen),
    .timeout_clocks(Tmo)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .pin    (pin),
    .status (st_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int sv_cnt = 0, ce_cnt = 0, fe_cnt = 0, multi_cnt = 0;

  logic [7:0]  exp_id  = 8'h00;
  logic [7:0]  exp_err = 8'h00;
  logic [15:0] exp_cnt = 16'h0000;
  logic [31:0] exp_val = 32'h0;

  logic [7:0] par_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pre_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_if.status_valid) sv_cnt++;
      if (st_if.crc_error) ce_cnt++;
      if (st_if.frame_error) fe_cnt++;
      if ((int'(st_if.status_valid) + int'(st_if.crc_error) + int'(st_if.frame_error)) > 1)
        multi_cnt++;
    end
  end

  // Reference CRC: bit-serial polynomial division over tx_q.
  function automatic logic [15:0] ref_crc();
    logic [15:0] r;
    bit fb;
    r = 16'h0000;
    foreach (tx_q[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = r[15] ^ tx_q[i][k];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  // Reference de-stuffing: an FD following wire bytes FF FF FD is not a parameter.
  task automatic model_params(output logic [15:0] cnt, output logic [31:0] val);
    bit dropped;
    cnt = 0;
    val = 0;
    for (int i = 0; i < par_q.size(); i++) begin
      dropped = (i >= 3) && par_q[i-3] == 8'hFF && par_q[i-2] == 8'hFF &&
                par_q[i-1] == 8'hFD && par_q[i] == 8'hFD;
      if (!dropped) begin
        if (cnt < 4) val = val | (32'(par_q[i]) << (8 * cnt));
        cnt++;
      end
    end
  endtask

  task automatic build_pkt(input logic [7:0] pid, input logic [7:0] perr, input logic [7:0] instr,
                           input logic [15:0] len, input bit bad_crc);
    logic [15:0] c;
    tx_q = {};
    tx_q.push_back(8'hFF); tx_q.push_back(8'hFF); tx_q.push_back(8'hFD); tx_q.push_back(8'h00);
    tx_q.push_back(pid);
    tx_q.push_back(len[7:0]);
    tx_q.push_back(len[15:8]);
    tx_q.push_back(instr);
    tx_q.push_back(perr);
    foreach (par_q[i]) tx_q.push_back(par_q[i]);
    c = ref_crc();
    if (bad_crc) c = c ^ (16'h0001 << $urandom_range(0, 15));
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    pin = 1'b0;
    repeat (Cpb) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      repeat (Cpb) @(posedge clk);
    end
    pin = stop_ok;
    repeat (Cpb) @(posedge clk);
    pin = 1'b1;
    if (!stop_ok) repeat (Cpb) @(posedge clk);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  // Sends the prefix then the first n bytes of tx_q.
  task automatic send_pkt(input int n);
    foreach (pre_q[i]) send_byte(pre_q[i], 1'b1);
    pre_q = {};
    for (int i = 0; i < n; i++) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic settle();
    repeat (3 * Cpb) @(negedge clk);
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".id"}, 32'(st_if.id), 32'(exp_id));
    check({tag, ".err"}, 32'(st_if.error), 32'(exp_err));
    check({tag, ".cnt"}, 32'(st_if.param_count), 32'(exp_cnt));
    check({tag, ".val"}, st_if.value, exp_val);
  endtask

  task automatic run_good(input string tag, input logic [7:0] pid, input logic [7:0] perr);
    int sv0, ce0, fe0;
    logic [15:0] cnt;
    logic [31:0] val;
    build_pkt(pid, perr, 8'h55, 16'(4 + par_q.size()), 1'b0);
    model_params(cnt, val);
    sv0 = sv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
    send_pkt(tx_q.size());
    settle();
    exp_id = pid; exp_err = perr; exp_cnt = cnt; exp_val = val;
    check({tag, ".status_valid"}, sv_cnt - sv0, 1);
    check({tag, ".no_err"}, (ce_cnt - ce0) + (fe_cnt - fe0), 0);
    check({tag, ".busy"}, 32'(st_if.busy), 0);
    check_fields(tag);
  endtask

  task automatic run_crc_bad(input string tag, input logic [7:0] pid, input logic [7:0] perr);
    int sv0, ce0, fe0;
    build_pkt(pid, perr, 8'h55, 16'(4 + par_q.size()), 1'b1);
    sv0 = sv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
    send_pkt(tx_q.size());
    settle();
    check({tag, ".crc_error"}, ce_cnt - ce0, 1);
    check({tag, ".no_other"}, (sv_cnt - sv0) + (fe_cnt - fe0), 0);
    check_fields(tag);
  endtask

  // tx_q already built; sends n bytes and expects exactly one frame_error.
  task automatic run_frame_bad(input string tag, input int n);
    int sv0, ce0, fe0;
    sv0 = sv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
    send_pkt(n);
    settle();
    check({tag, ".frame_error"}, fe_cnt - fe0, 1);
    check({tag, ".no_other"}, (sv_cnt - sv0) + (ce_cnt - ce0), 0);
    check({tag, ".busy"}, 32'(st_if.busy), 0);
    check_fields(tag);
  endtask

  task automatic load_pkt1();
    par_q = {8'hA6, 8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, sv0, waited;
    logic [7:0] b;
    logic [15:0] blen;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.status_valid", 32'(st_if.status_valid), 0);
    check("rst.crc_error", 32'(st_if.crc_error), 0);
    check("rst.frame_error", 32'(st_if.frame_error), 0);
    check("rst.busy", 32'(st_if.busy), 0);
    check_fields("rst");

    // packet 1
    load_pkt1();
    run_good("c1", 8'h01, 8'h00);
    // stuffed parameters
    par_q = {8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h07};
    run_good("c4", 8'h01, 8'h00);
    check("c4.lit_val", st_if.value, 32'h07FD_FFFF);
    check("c4.lit_cnt", 32'(st_if.param_count), 4);
    // bad CRC leaves the stuffed-packet fields in place, then packet 1 passes again
    load_pkt1();
    run_crc_bad("c2", 8'h01, 8'h00);
    run_good("c2b", 8'h01, 8'h00);
    // garbage before the header
    par_q = {8'h11, 8'h22};
    pre_q = {8'h12, 8'hFF};
    run_good("c3", 8'h07, 8'h00);
    load_pkt1();
    pre_q = {8'h12, 8'hFF};
    run_good("c3b", 8'h01, 8'h00);
    // no params
    par_q = {};
    run_good("len4", 8'h2C, 8'h80);

    // truncated packet times out
    load_pkt1();
    build_pkt(8'h01, 8'h00, 8'h55, 16'd8, 1'b0);
    send_pkt(9);
    @(negedge clk);
    check("c5.busy_before", 32'(st_if.busy), 1);
    fe0 = fe_cnt;
    waited = 0;
    while (fe_cnt == fe0 && waited < int'(Tmo) + 100) begin
      @(negedge clk);
      waited++;
    end
    check("c5.frame_error", fe_cnt - fe0, 1);
    check("c5.not_early", 32'(waited >= int'(Tmo) - 3 * int'(Cpb)), 1);
    @(negedge clk);
    check("c5.busy_after", 32'(st_if.busy), 0);
    run_good("c5b", 8'h01, 8'h00);

    // wrong instruction
    par_q = {8'h01};
    build_pkt(8'h03, 8'h00, 8'h83, 16'd5, 1'b0);
    run_frame_bad("c6.instr", 8);
    // stop bit forced low
    fe0 = fe_cnt; sv0 = sv_cnt;
    send_byte(8'h5A, 1'b0);
    settle();
    check("c6.stop.frame_error", fe_cnt - fe0, 1);
    check("c6.stop.no_status", sv_cnt - sv0, 0);

    // reset in the middle of a packet
    load_pkt1();
    build_pkt(8'h09, 8'h00, 8'h55, 16'd8, 1'b0);
    send_pkt(6);
    @(negedge clk);
    check("c6.rst.busy_before", 32'(st_if.busy), 1);
    fe0 = fe_cnt;
    #2 rst_n = 1'b0;
    @(negedge clk);
    exp_id = 0; exp_err = 0; exp_cnt = 0; exp_val = 0;
    check("c6.rst.busy", 32'(st_if.busy), 0);
    check_fields("c6.rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    check("c6.rst.no_pulse", fe_cnt - fe0, 0);
    check_fields("c6.rst_after");
    run_good("c6.rst_recover", 8'h0A, 8'h01);

    // randomised packets
    for (int it = 0; it < 14; it++) begin
      int kind;
      int np;
      kind = $urandom_range(0, 9);
      np = $urandom_range(0, 12);
      par_q = {};
      for (int j = 0; j < np; j++) begin
        case ($urandom_range(0, 3))
          0: par_q.push_back(8'hFF);
          1: par_q.push_back(8'hFD);
          default: par_q.push_back(8'($urandom));
        endcase
      end
      pre_q = {};
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        b = 8'($urandom);
        if (b == 8'hFD) b = 8'h00;
        pre_q.push_back(b);
      end
      if (kind <= 5) begin
        run_good($sformatf("rnd%0d.good", it), 8'($urandom), 8'($urandom));
      end else if (kind <= 7) begin
        run_crc_bad($sformatf("rnd%0d.crc", it), 8'($urandom), 8'($urandom));
      end else if (kind == 8) begin
        if ($urandom_range(0, 1) == 1) blen = 16'($urandom_range(0, 3));
        else blen = MaxLen + 16'd1 + 16'($urandom_range(0, 300));
        build_pkt(8'($urandom), 8'h00, 8'h55, blen, 1'b0);
        run_frame_bad($sformatf("rnd%0d.len", it), 7);
      end else begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h83;
        build_pkt(8'($urandom), 8'h00, b, 16'(4 + par_q.size()), 1'b0);
        run_frame_bad($sformatf("rnd%0d.instr", it), 8);
      end
    end

    check("exclusive_pulses", multi_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
